// File: rtl/inst_fetcher_pkg.sv
// Shared constants, types and helpers for the instruction fetch front end.
// Holds the opcode encodings, the queue entry layout and the static predictor.
package inst_fetcher_pkg;

  localparam int INST_W = 32;
  localparam int DATA_W = 32;
  localparam int IQ_DEPTH_DEFAULT = 16;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [6:0] OPCODE_BR  = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] pc;
    logic              pred_jump;
    logic [DATA_W-1:0] pred_pc;
  } iq_entry_t;

  // Queue pointer width; the occupancy counter needs one extra bit.
  function automatic int iq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Static prediction: JAL and backward conditional branches are taken.
  function automatic iq_entry_t predict(input logic [INST_W-1:0] inst,
                                        input logic [DATA_W-1:0] pc);
    iq_entry_t         e;
    logic [DATA_W-1:0] j_imm;
    logic [DATA_W-1:0] b_imm;
    j_imm       = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm       = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    e.inst      = inst;
    e.pc        = pc;
    e.pred_jump = 1'b0;
    e.pred_pc   = pc + 32'd4;
    if (inst[6:0] == OPCODE_JAL) begin
      e.pred_jump = 1'b1;
      e.pred_pc   = pc + j_imm;
    end else if (inst[6:0] == OPCODE_BR && inst[31]) begin
      e.pred_jump = 1'b1;
      e.pred_pc   = pc + b_imm;
    end
    return e;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-side bus: icache request/response plus the head-of-queue handoff to dispatch.
// The fetcher is the master; the icache/dispatch environment is the slave.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic              icache_req_valid;
  logic [DATA_W-1:0] icache_req_pc;
  logic              icache_resp_valid;
  logic [INST_W-1:0] icache_resp_inst;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [DATA_W-1:0] inst_pc;
  logic              inst_pred_jump;
  logic [DATA_W-1:0] inst_pred_pc;
  logic              dispatch_ready;

  modport master (
    output icache_req_valid, icache_req_pc,
    output inst_valid, inst, inst_pc, inst_pred_jump, inst_pred_pc,
    input  icache_resp_valid, icache_resp_inst, dispatch_ready
  );

  modport slave (
    input  icache_req_valid, icache_req_pc,
    input  inst_valid, inst, inst_pc, inst_pred_jump, inst_pred_pc,
    output icache_resp_valid, icache_resp_inst, dispatch_ready
  );

endinterface

// File: rtl/inst_fetcher_queue.sv
// Circular instruction queue between fetch and dispatch.
// Clear wins over enqueue/dequeue; the head entry is presented combinationally.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enq,
  input  logic                      deq,
  input  iq_entry_t                 enq_entry,
  output iq_entry_t                 head_entry,
  output logic [iq_ptr_w(DEPTH):0]  count
);

  localparam int PW = iq_ptr_w(DEPTH);

  iq_entry_t         mem [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  assign head_entry = mem[head_ptr];

  // Storage is reset too so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        mem[tail_ptr] <= enq_entry;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (deq) head_ptr <= head_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: owns the fetch PC, issues one-word icache requests, predicts
// the next PC statically and queues fetched instructions for dispatch.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH = IQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     flush_pc,
  inst_fetcher_if.master        bus
);

  localparam int             CW   = iq_ptr_w(IQ_DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(IQ_DEPTH);

  fetch_state_t      state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] req_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  iq_entry_t         resp_entry;
  iq_entry_t         head_entry;
  logic              head_valid;
  logic              enq;
  logic              deq;
  logic              clear;

  assign resp_entry = predict(bus.icache_resp_inst, pc);
  assign head_valid = (count != '0) && !flush;
  assign enq        = rdy && !flush && (state == S_WAIT) && bus.icache_resp_valid;
  assign deq        = rdy && head_valid && bus.dispatch_ready;
  assign clear      = rdy && flush;
  assign count_next = count + CW'(enq) - CW'(deq);

  inst_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .enq       (enq),
    .deq       (deq),
    .enq_entry (resp_entry),
    .head_entry(head_entry),
    .count     (count)
  );

  // An outstanding request that is flushed without its response must still be
  // drained, so it parks in DISCARD until the stale response arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (rdy) begin
      if (flush) begin
        pc <= flush_pc;
        if (state != S_IDLE && !bus.icache_resp_valid) state <= S_DISCARD;
        else                                            state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (count < FULL) begin
              state  <= S_WAIT;
              req_pc <= pc;
            end
          end
          S_WAIT: begin
            if (bus.icache_resp_valid) begin
              pc <= resp_entry.pred_pc;
              if (count_next < FULL) req_pc <= resp_entry.pred_pc;
              else                   state  <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (bus.icache_resp_valid) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.icache_req_valid = (state != S_IDLE);
  assign bus.icache_req_pc    = req_pc;
  assign bus.inst_valid       = head_valid;
  assign bus.inst             = head_entry.inst;
  assign bus.inst_pc          = head_entry.pc;
  assign bus.inst_pred_jump   = head_entry.pred_jump;
  assign bus.inst_pred_pc     = head_entry.pred_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: an icache responder, a dispatch monitor
// and a directed sequence of fetch, prediction, flush, stall and reset scenarios.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pj;
    logic [31:0] ppc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        auto_valid;
  logic [31:0] auto_inst;
  logic        man_valid = 1'b0;
  logic [31:0] man_inst = 32'h0;
  bit          auto_resp = 1'b0;
  bit          fwd_branch = 1'b0;
  int          served = 0;
  int          serve_limit = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];

  inst_fetcher_if bus();

  inst_fetcher #(
    .IQ_DEPTH(16),
    .RESET_PC(32'h0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdy     (rdy),
    .flush   (flush),
    .flush_pc(flush_pc),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.icache_resp_valid = auto_resp ? auto_valid : man_valid;
  assign bus.icache_resp_inst  = auto_resp ? auto_inst  : man_inst;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h10) return 32'h0080006F;
    if (a == 32'h20) return fwd_branch ? 32'h00000263 : 32'hFE000EE3;
    return 32'h00000013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f,
                               input logic [31:0] fpc, input logic dr);
    @(negedge clk);
    rdy                = r;
    flush              = f;
    flush_pc           = fpc;
    bus.dispatch_ready = dr;
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p,
                          input logic j, input logic [31:0] np);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    e.pj   = j;
    e.ppc  = np;
    exp_q.push_back(e);
  endtask

  task automatic wait_quiet(input string name, input bit need_empty);
    int n;
    n = 0;
    while (n < 200 && !((!need_empty || exp_q.size() == 0) &&
                        served >= serve_limit && !auto_valid)) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: timeout, got %0d pending, required 0", name, exp_q.size());
    end
    @(negedge clk);
  endtask

  // Responds one cycle after each request, up to serve_limit responses.
  initial begin
    bit took;
    auto_valid = 1'b0;
    auto_inst  = 32'h0;
    forever begin
      @(posedge clk);
      took = auto_valid && rdy && rst_n;
      @(negedge clk);
      if (took) auto_valid = 1'b0;
      if (auto_resp && !auto_valid && bus.icache_req_valid && served < serve_limit) begin
        auto_valid = 1'b1;
        auto_inst  = imem(bus.icache_req_pc);
        served++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rdy && bus.inst_valid && bus.dispatch_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_dispatch: got pc %h, required no instruction", bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_inst", bus.inst, e.inst);
          checkOutput("sb_pc", bus.inst_pc, e.pc);
          checkOutput("sb_pred_jump", bus.inst_pred_jump, e.pj);
          checkOutput("sb_pred_pc", bus.inst_pred_pc, e.ppc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    bus.dispatch_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_req_valid", bus.icache_req_valid, 0);
    checkOutput("reset_req_pc", bus.icache_req_pc, 0);
    checkOutput("reset_inst_valid", bus.inst_valid, 0);
    checkOutput("reset_inst", bus.inst, 0);
    checkOutput("reset_pred_pc", bus.inst_pred_pc, 0);

    // Straight-line fetch, JAL and a backward branch looping 0x1C/0x20.
    push_exp(32'h13, 32'h00, 0, 32'h04);
    push_exp(32'h13, 32'h04, 0, 32'h08);
    push_exp(32'h13, 32'h08, 0, 32'h0C);
    push_exp(32'h13, 32'h0C, 0, 32'h10);
    push_exp(32'h0080006F, 32'h10, 1, 32'h18);
    push_exp(32'h13, 32'h18, 0, 32'h1C);
    push_exp(32'h13, 32'h1C, 0, 32'h20);
    push_exp(32'hFE000EE3, 32'h20, 1, 32'h1C);
    push_exp(32'h13, 32'h1C, 0, 32'h20);
    push_exp(32'hFE000EE3, 32'h20, 1, 32'h1C);
    auto_resp   = 1'b1;
    serve_limit = served + 10;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 1);
    wait_quiet("stream_a", 1);
    checkOutput("loop_req_valid", bus.icache_req_valid, 1);
    checkOutput("loop_req_pc", bus.icache_req_pc, 32'h1C);

    // Flush while a request is outstanding and the queue holds two entries.
    applyStimulus(1, 0, 0, 0);
    serve_limit = served + 2;
    wait_quiet("fill_b", 1);
    auto_resp = 1'b0;
    applyStimulus(1, 1, 32'h100, 0);
    #2 checkOutput("flush_inst_valid", bus.inst_valid, 0);
    applyStimulus(1, 0, 0, 0);
    #2;
    checkOutput("discard_req_valid", bus.icache_req_valid, 1);
    checkOutput("discard_req_pc", bus.icache_req_pc, 32'h1C);
    checkOutput("flush_cleared", bus.inst_valid, 0);
    repeat (2) applyStimulus(1, 0, 0, 0);
    #2 checkOutput("discard_hold_pc", bus.icache_req_pc, 32'h1C);
    @(negedge clk);
    man_valid = 1'b1;
    man_inst  = 32'h0080006F;
    @(negedge clk);
    man_valid = 1'b0;
    #2 checkOutput("discard_drop_idle", bus.icache_req_valid, 0);
    @(negedge clk);
    #2;
    checkOutput("redirect_req_valid", bus.icache_req_valid, 1);
    checkOutput("redirect_req_pc", bus.icache_req_pc, 32'h100);
    checkOutput("stale_not_queued", bus.inst_valid, 0);
    push_exp(32'h13, 32'h100, 0, 32'h104);
    push_exp(32'h13, 32'h104, 0, 32'h108);
    applyStimulus(1, 0, 0, 1);
    auto_resp   = 1'b1;
    serve_limit = served + 2;
    wait_quiet("resume_b", 1);

    // Flush coinciding with a response, then a forward branch at 0x20.
    auto_resp = 1'b0;
    @(negedge clk);
    flush     = 1'b1;
    flush_pc  = 32'h1C;
    man_valid = 1'b1;
    man_inst  = 32'h13;
    @(negedge clk);
    flush     = 1'b0;
    man_valid = 1'b0;
    #2;
    checkOutput("flush_resp_idle", bus.icache_req_valid, 0);
    checkOutput("flush_resp_dropped", bus.inst_valid, 0);
    @(negedge clk);
    #2;
    checkOutput("flush_resp_req_valid", bus.icache_req_valid, 1);
    checkOutput("flush_resp_req_pc", bus.icache_req_pc, 32'h1C);
    fwd_branch = 1'b1;
    push_exp(32'h13, 32'h1C, 0, 32'h20);
    push_exp(32'h00000263, 32'h20, 0, 32'h24);
    push_exp(32'h13, 32'h24, 0, 32'h28);
    auto_resp   = 1'b1;
    serve_limit = served + 3;
    wait_quiet("fwd_c", 1);

    // Dispatch stalled for 40 cycles: exactly 16 entries, then fetch stops.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) push_exp(32'h13, 32'h28 + 4 * i, 0, 32'h2C + 4 * i);
    start       = served;
    serve_limit = served + 100;
    repeat (40) @(negedge clk);
    #2;
    checkOutput("full_accepted", served - start, 16);
    checkOutput("full_req_valid", bus.icache_req_valid, 0);
    checkOutput("full_inst_valid", bus.inst_valid, 1);
    checkOutput("full_head_pc", bus.inst_pc, 32'h28);
    serve_limit = served + 2;
    push_exp(32'h13, 32'h68, 0, 32'h6C);
    push_exp(32'h13, 32'h6C, 0, 32'h70);
    applyStimulus(1, 0, 0, 1);
    wait_quiet("drain_d", 1);
    checkOutput("drain_served", served - start, 18);

    // rdy low for 5 cycles with a response pending and dispatch ready.
    applyStimulus(1, 0, 0, 0);
    push_exp(32'h13, 32'h70, 0, 32'h74);
    push_exp(32'h13, 32'h74, 0, 32'h78);
    push_exp(32'h13, 32'h78, 0, 32'h7C);
    push_exp(32'h13, 32'h7C, 0, 32'h80);
    serve_limit = served + 3;
    wait_quiet("fill_e", 0);
    applyStimulus(0, 0, 0, 1);
    serve_limit = served + 1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 1);
      #2;
      checkOutput("freeze_inst_valid", bus.inst_valid, 1);
      checkOutput("freeze_head_pc", bus.inst_pc, 32'h70);
      checkOutput("freeze_req_pc", bus.icache_req_pc, 32'h7C);
    end
    applyStimulus(1, 0, 0, 1);
    wait_quiet("drain_e", 1);

    // Asynchronous reset mid-request with a non-empty queue.
    applyStimulus(1, 0, 0, 0);
    serve_limit = served + 1;
    wait_quiet("fill_f", 0);
    auto_resp = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_req_valid", bus.icache_req_valid, 0);
    checkOutput("arst_req_pc", bus.icache_req_pc, 0);
    checkOutput("arst_inst_valid", bus.inst_valid, 0);
    checkOutput("arst_inst_pc", bus.inst_pc, 0);
    checkOutput("arst_pred_jump", bus.inst_pred_jump, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    man_valid = 1'b1;
    man_inst  = 32'h0080006F;
    @(negedge clk);
    man_valid = 1'b0;
    #2;
    checkOutput("post_reset_req_valid", bus.icache_req_valid, 1);
    checkOutput("post_reset_req_pc", bus.icache_req_pc, 0);
    checkOutput("post_reset_ignored", bus.inst_valid, 0);
    push_exp(32'h13, 32'h0, 0, 32'h4);
    applyStimulus(1, 0, 0, 1);
    auto_resp   = 1'b1;
    serve_limit = served + 1;
    wait_quiet("restart_f", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
